// File: rtl/sqrt_reconstruct.sv
// Rebuilds a radicand from an integer square root and remainder as root*root + remainder.
// Latency RESULT_WIDTH+1 cycles, one item per cycle, no backpressure.
module sqrt_reconstruct #(
  parameter int RESULT_WIDTH = 14
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [RESULT_WIDTH-1:0]   root,
  input  logic [RESULT_WIDTH+1:0]   remainder,
  output logic                      out_valid,
  output logic [2*RESULT_WIDTH-1:0] integer_output,
  output logic                      out_error
);

  localparam int W     = RESULT_WIDTH;
  localparam int ACC_W = 2 * W + 1;

  logic [W:0]       vld_q;
  logic [W:0]       flag_q;
  logic [W-1:0]     root_q [W];
  logic [ACC_W-1:0] acc_q  [W+1];

  // Stage 0 seeds the accumulator with the remainder; stage k adds the
  // partial product for root bit k-1. The last stage needs no root copy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q  <= '0;
      flag_q <= '0;
      for (int k = 0; k < W; k++) root_q[k] <= '0;
      for (int k = 0; k <= W; k++) acc_q[k] <= '0;
    end else begin
      vld_q[0]  <= in_valid;
      flag_q[0] <= in_valid && (remainder > {1'b0, root, 1'b0});
      root_q[0] <= in_valid ? root : '0;
      acc_q[0]  <= in_valid ? ACC_W'(remainder) : '0;
      for (int k = 1; k <= W; k++) begin
        vld_q[k]  <= vld_q[k-1];
        flag_q[k] <= flag_q[k-1];
        acc_q[k]  <= acc_q[k-1] +
                     (root_q[k-1][k-1] ? (ACC_W'(root_q[k-1]) << (k - 1)) : '0);
      end
      for (int k = 1; k < W; k++) root_q[k] <= root_q[k-1];
    end
  end

  // Registered output: zero on bubbles, all ones on a non-canonical pair.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid      <= 1'b0;
      out_error      <= 1'b0;
      integer_output <= '0;
    end else begin
      out_valid <= vld_q[W];
      out_error <= vld_q[W] && flag_q[W];
      if (!vld_q[W])
        integer_output <= '0;
      else if (flag_q[W] || acc_q[W][ACC_W-1])
        integer_output <= '1;
      else
        integer_output <= acc_q[W][2*W-1:0];
    end
  end

endmodule

// File: tb/tb_sqrt_reconstruct.sv
// Directed-vector and scoreboard bench for sqrt_reconstruct at RESULT_WIDTH=14.
module tb_sqrt_reconstruct;

  localparam int W   = 14;
  localparam int LAT = W + 1;
  localparam logic [2*W-1:0] ALL1 = '1;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic [W-1:0]   root;
  logic [W+1:0]   remainder;
  logic           out_valid;
  logic [2*W-1:0] integer_output;
  logic           out_error;

  sqrt_reconstruct #(.RESULT_WIDTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .root           (root),
    .remainder      (remainder),
    .out_valid      (out_valid),
    .integer_output (integer_output),
    .out_error      (out_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   r;
    logic [W+1:0]   m;
    logic [2*W-1:0] e_out;
    logic           e_err;
  } vec_t;

  typedef struct {
    logic [2*W-1:0] e_out;
    logic           e_err;
    int             t;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every valid output must match the oldest expected item at exact latency.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output cyc=%0d out=%0d err=%0b expected none", cyc, integer_output, out_error);
      end else begin
        e = q.pop_front();
        checks += 3;
        if (integer_output !== e.e_out) begin
          errors++;
          $display("FAIL data cyc=%0d got=%0d exp=%0d", cyc, integer_output, e.e_out);
        end
        if (out_error !== e.e_err) begin
          errors++;
          $display("FAIL error_flag cyc=%0d got=%0b exp=%0b", cyc, out_error, e.e_err);
        end
        if (cyc - e.t != LAT) begin
          errors++;
          $display("FAIL latency got=%0d exp=%0d", cyc - e.t, LAT);
        end
      end
    end else begin
      checks++;
      if (out_valid !== 1'b0 || integer_output !== '0 || out_error !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs cyc=%0d valid=%0b out=%0d err=%0b exp 0/0/0",
                 cyc, out_valid, integer_output, out_error);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [W-1:0] r, input logic [W+1:0] m,
                       input logic [2*W-1:0] e_out, input logic e_err);
    exp_t e;
    in_valid  = v;
    root      = r;
    remainder = m;
    if (v && reset) begin
      e.e_out = e_out; e.e_err = e_err; e.t = cyc + 1;
      q.push_back(e);
    end
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      issue(1'b0, W'($urandom), (W+2)'($urandom), '0, 1'b0);
  endtask

  task automatic check_now(input string name, input logic v, input logic [2*W-1:0] o, input logic er);
    checks++;
    if (out_valid !== v || integer_output !== o || out_error !== er) begin
      errors++;
      $display("FAIL %s got=%0b/%0d/%0b exp=%0b/%0d/%0b", name,
               out_valid, integer_output, out_error, v, o, er);
    end
  endtask

  function automatic logic [W-1:0] isqrt(input logic [2*W-1:0] v);
    logic [W-1:0] r;
    logic [W-1:0] t;
    r = '0;
    for (int b = W - 1; b >= 0; b--) begin
      t = r | (W'(1) << b);
      if ({{W{1'b0}}, t} * {{W{1'b0}}, t} <= {{W{1'b0}}, v}) r = t;
    end
    return r;
  endfunction

  vec_t vecs[12];

  initial begin
    logic [W-1:0]   r;
    logic [W+1:0]   m;
    logic [2*W-1:0] v;

    vecs[0]  = '{14'd5,     16'd3,     28'd28,        1'b0};
    vecs[1]  = '{14'd0,     16'd0,     28'd0,         1'b0};
    vecs[2]  = '{14'd16383, 16'd32766, 28'd268435455, 1'b0};
    vecs[3]  = '{14'd5,     16'd11,    ALL1,          1'b1};
    vecs[4]  = '{14'd0,     16'd65535, ALL1,          1'b1};
    vecs[5]  = '{14'd1,     16'd2,     28'd3,         1'b0};
    vecs[6]  = '{14'd1,     16'd3,     ALL1,          1'b1};
    vecs[7]  = '{14'd100,   16'd200,   28'd10200,     1'b0};
    vecs[8]  = '{14'd12345, 16'd0,     28'd152399025, 1'b0};
    vecs[9]  = '{14'd16383, 16'd0,     28'd268402689, 1'b0};
    vecs[10] = '{14'd255,   16'd510,   28'd65535,     1'b0};
    vecs[11] = '{14'd16383, 16'd65535, ALL1,          1'b1};

    // Reset with in_valid high: nothing may enter the pipeline.
    reset = 1'b0; in_valid = 1'b1; root = 14'd7; remainder = 16'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_now("reset_state", 1'b0, '0, 1'b0);
    end
    reset = 1'b1;
    idle(LAT + 2);

    // Single item, hand-checked latency edge.
    issue(1'b1, 14'd5, 16'd3, 28'd28, 1'b0);
    idle(LAT - 1);
    check_now("basic_before", 1'b0, '0, 1'b0);
    idle(1);
    check_now("basic_at_latency", 1'b1, 28'd28, 1'b0);
    idle(LAT);

    // Table vectors back-to-back, then again with a bubble after each.
    foreach (vecs[i]) issue(1'b1, vecs[i].r, vecs[i].m, vecs[i].e_out, vecs[i].e_err);
    foreach (vecs[i]) begin
      issue(1'b1, vecs[i].r, vecs[i].m, vecs[i].e_out, vecs[i].e_err);
      idle(1);
    end
    idle(LAT + 2);

    // Random canonical stream with random gaps.
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      r = W'($urandom);
      m = (W+2)'($urandom_range(0, 2 * int'(r)));
      v = 28'({14'd0, r} * {14'd0, r}) + 28'(m);
      issue(1'b1, r, m, v, 1'b0);
    end
    idle(LAT + 2);

    // Reset for one cycle in the middle of an 8-item burst.
    for (int i = 0; i < 8; i++) begin
      r = W'(i * 37 + 3);
      m = (W+2)'(i);
      if (i == 5) begin
        reset = 1'b0; in_valid = 1'b1; root = r; remainder = m;
        q.delete();
        tick();
        check_now("midflight_reset", 1'b0, '0, 1'b0);
        reset = 1'b1;
      end else begin
        issue(1'b1, r, m, 28'({14'd0, r} * {14'd0, r}) + 28'(m), 1'b0);
      end
    end
    idle(LAT + 2);

    // Round trip through an independent integer square root.
    for (int i = 0; i < 200; i++) begin
      v = 28'($urandom);
      if (i == 0) v = ALL1;
      r = isqrt(v);
      m = (W+2)'(v - 28'({14'd0, r} * {14'd0, r}));
      issue(1'b1, r, m, v, 1'b0);
    end
    idle(LAT + 3);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_outputs got=%0d pending exp=0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sqrt_reconstruct.md
SQRT_RECONSTRUCT -- requirements
Module: sqrt_reconstruct

Interface
REQ-001 The block SHALL have parameter RESULT_WIDTH, default 14, giving the root width W; the square width is 2W.
REQ-002 The block SHALL have input clk, 1 bit: clock, all state updates on the rising edge.
REQ-003 The block SHALL have input reset, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have input in_valid, 1 bit: root and remainder are valid this cycle.
REQ-005 The block SHALL have input root, W bits: unsigned integer square root.
REQ-006 The block SHALL have input remainder, W+2 bits: unsigned remainder paired with root.
REQ-007 The block SHALL have output out_valid, 1 bit: the output word is valid this cycle.
REQ-008 The block SHALL have output integer_output, 2W bits: reconstructed radicand, root*root + remainder.
REQ-009 The block SHALL have output out_error, 1 bit: the pair was non-canonical (remainder > 2*root).

Function
REQ-010 The block SHALL be fully pipelined: it accepts one input per cycle with in_valid high, with no backpressure and no gaps required.
REQ-011 Stage 0 SHALL register root, remainder, in_valid and the compare flag remainder > 2*root; the accumulator starts at zero-extended remainder.
REQ-012 Stages 1..W SHALL each handle one root bit, stage k adding (root << (k-1)) when root bit k-1 is 1; root, flag and valid travel with the data.
REQ-013 Latency SHALL be exactly W+1 rising edges from the edge sampling in_valid=1 to the cycle out_valid=1 for that item.
REQ-014 Output order SHALL match input order; each valid input SHALL produce exactly one valid output.
REQ-015 Accumulator width SHALL be 2W+1 bits internally so that no intermediate sum wraps.
REQ-016 When the flag is clear, integer_output SHALL equal root*root + remainder; it is never above 2^(2W)-1.
REQ-017 When the flag is set, out_error SHALL be 1 and integer_output SHALL saturate to all ones (2^(2W)-1) with out_valid still 1.
REQ-018 When out_valid is 0, integer_output and out_error SHALL both be 0.
REQ-019 An in_valid=0 cycle SHALL make a bubble that comes out as out_valid=0 exactly W+1 cycles later; data inputs are ignored in that cycle.
REQ-020 The boundary root=2^W-1 with remainder=2^(W+1)-2 SHALL give 2^(2W)-1 with out_error=0.
REQ-021 The boundary remainder=2^(W+2)-1 with any root SHALL set out_error.

Reset
REQ-022 While reset=0 at a rising edge, every stage valid bit, accumulator, carried root and flag SHALL clear to 0.
REQ-023 Outputs SHALL be out_valid=0, integer_output=0 and out_error=0 from the first edge with reset low, and while reset stays low.
REQ-024 Items in flight when reset asserts SHALL be discarded and never show up at the output.
REQ-025 in_valid sampled while reset=0 SHALL be ignored.
REQ-026 The first edge with reset=1 SHALL accept input normally; the first output is W+1 edges later.
REQ-027 There SHALL be no output-fill counter: validity SHALL come only from the per-stage valid bits.

Verification (W=14)
REQ-028 Basic: root=5, remainder=3, one cycle -> out_valid=1 exactly 15 cycles later, integer_output=28, out_error=0.
REQ-029 Extremes: root=0, rem=0 -> 0; then root=16383, rem=32766 -> 268435455, out_error=0.
REQ-030 Error: root=5, rem=11 -> out_error=1, integer_output=268435455; root=0, rem=65535 -> out_error=1.
REQ-031 Streaming: 1000 back-to-back random canonical pairs with random in_valid gaps -> in-order outputs matching a reference model and gaps kept.
REQ-032 Reset mid-flight: 8 items issued, reset low for 1 cycle at item 5 -> no output from the flushed items; a new item after reset comes out at +15 cycles.
REQ-033 Round trip: random 28-bit values -> integer sqrt model -> this block -> the original value returned, out_error=0.
